// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmitter: FSM state encoding and the
// frame-counter width helper.
package i2s_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Bits needed to count 0 .. 2*slot-1.
  function automatic int cnt_width(input int slot);
    if (slot <= 1) begin
      return 1;
    end else begin
      return $clog2(2 * slot);
    end
  endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-pair handshake bus: the producer (master) offers a stereo pair,
// the transmitter (slave) accepts it when its holding register is empty.
interface i2s_transmitter_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_left;
  logic [WIDTH-1:0] in_right;

  modport master (output in_valid, output in_left, output in_right, input in_ready);
  modport slave  (input in_valid, input in_left, input in_right, output in_ready);
endinterface

// File: rtl/i2s_frame_timer.sv
// Frame timing for the I2S transmitter: owns the bit counter, the registered
// word-select line and the frame_start strobe that is high in the cycle
// before every edge that enters cnt=0.
module i2s_frame_timer
  import i2s_pkg::*;
#(
  parameter int SLOT = 8
) (
  input  logic sck,
  input  logic rst,
  input  logic en,
  output logic ws,
  output logic frame_start
);

  localparam int CW = cnt_width(SLOT);

  logic [0:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          ws_r;
  logic          wrap_s;
  logic          frame_start_s;

  // Next count, end-of-frame detect and frame-load strobe (en only matters here).
  always_comb begin
    cnt_nxt_s     = cnt_r + CW'(1);
    wrap_s        = (state_r == ST_RUN) && (cnt_r == CW'(2 * SLOT - 1));
    frame_start_s = 1'b0;
    if (state_r == ST_IDLE) begin
      frame_start_s = en;
    end else if (wrap_s) begin
      frame_start_s = en;
    end else begin
      frame_start_s = 1'b0;
    end
  end

  // State, counter and word select; ws is computed from the next count so it
  // stays aligned with cnt.
  always_ff @(posedge sck) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CW{1'b0}};
      ws_r    <= 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (en) begin
            state_r <= ST_RUN;
            ws_r    <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            ws_r    <= 1'b1;
          end
        end
        ST_RUN: begin
          if (wrap_s) begin
            cnt_r <= {CW{1'b0}};
            if (en) begin
              state_r <= ST_RUN;
              ws_r    <= 1'b0;
            end else begin
              state_r <= ST_IDLE;
              ws_r    <= 1'b1;
            end
          end else begin
            state_r <= ST_RUN;
            cnt_r   <= cnt_nxt_s;
            ws_r    <= (cnt_nxt_s >= CW'(SLOT));
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CW{1'b0}};
          ws_r    <= 1'b1;
        end
      endcase
    end
  end

  assign ws          = ws_r;
  assign frame_start = frame_start_s;

endmodule

// File: rtl/i2s_transmitter.sv
// I2S bus master transmitter: one-entry holding register behind a
// valid/ready handshake, a 2*SLOT-bit frame shift register and the
// registered sd/underflow outputs. Timing comes from i2s_frame_timer.
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLOT  = 8
) (
  input  logic                sck,
  input  logic                rst,
  input  logic                en,
  i2s_transmitter_if.slave    in_bus,
  output logic                ws,
  output logic                sd,
  output logic                underflow
);

  localparam int FW = 2 * SLOT;

  logic             frame_start_s;
  logic             ws_s;
  logic             xfer_s;
  logic [FW-1:0]    frame_s;
  logic [WIDTH-1:0] hold_left_r;
  logic [WIDTH-1:0] hold_right_r;
  logic             hold_empty_r;
  logic [FW-1:0]    shift_r;
  logic             sd_r;
  logic             underflow_r;

  i2s_frame_timer #(.SLOT(SLOT)) u_timer (
    .sck         (sck),
    .rst         (rst),
    .en          (en),
    .ws          (ws_s),
    .frame_start (frame_start_s)
  );

  // Handshake transfer and the frame image: left MSB-first then right, each
  // zero-padded to SLOT bits; an empty holding register yields a silent frame.
  always_comb begin
    xfer_s  = in_bus.in_valid && hold_empty_r;
    frame_s = {FW{1'b0}};
    if (hold_empty_r) begin
      frame_s = {FW{1'b0}};
    end else begin
      frame_s = (FW'(hold_left_r) << (FW - WIDTH)) | (FW'(hold_right_r) << (SLOT - WIDTH));
    end
  end

  // Holding register: drained by a frame load, filled by a transfer (no bypass).
  always_ff @(posedge sck) begin
    if (!rst) begin
      hold_empty_r <= 1'b1;
      hold_left_r  <= {WIDTH{1'b0}};
      hold_right_r <= {WIDTH{1'b0}};
    end else if (frame_start_s && !hold_empty_r) begin
      hold_empty_r <= 1'b1;
    end else if (xfer_s) begin
      hold_empty_r <= 1'b0;
      hold_left_r  <= in_bus.in_left;
      hold_right_r <= in_bus.in_right;
    end else begin
      hold_empty_r <= hold_empty_r;
    end
  end

  // Shift register and sd: sd always takes the MSB one edge later, which gives
  // the one-bit I2S delay and lets the last bit spill into the next cnt=0 cycle.
  // Zeros shift in, so the register is empty while idle.
  always_ff @(posedge sck) begin
    if (!rst) begin
      shift_r <= {FW{1'b0}};
      sd_r    <= 1'b0;
    end else begin
      sd_r <= shift_r[FW-1];
      if (frame_start_s) begin
        shift_r <= frame_s;
      end else begin
        shift_r <= {shift_r[FW-2:0], 1'b0};
      end
    end
  end

  // Underflow pulse for the cnt=0 cycle of a frame loaded with no data.
  always_ff @(posedge sck) begin
    if (!rst) begin
      underflow_r <= 1'b0;
    end else begin
      underflow_r <= frame_start_s && hold_empty_r;
    end
  end

  assign ws              = ws_s;
  assign sd              = sd_r;
  assign underflow       = underflow_r;
  assign in_bus.in_ready = hold_empty_r;

endmodule
